control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 32, for instruction/data width; WIDTH >= 32.
REQ-002 SHALL have parameter MAX_WAIT, default 16, for the maximum number of cycles spent waiting on mem_ready.
REQ-003 SHALL have parameter CNT_W, default 32, for the width of the retired-instruction counter.
REQ-004 clk  in  1  sole clock; all state changes on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ir  in  WIDTH  current instruction: cond=ir[WIDTH-1:WIDTH-4], op=ir[WIDTH-5:WIDTH-8], dst=ir[23:20], srcA=ir[19:16], srcB=ir[15:12], alu_op=ir[11:8].
REQ-007 status  in  status_t  zero/carry/negative/overflow flags.
REQ-008 mem_ready  in  1  memory completes the current rd/wr in this cycle.
REQ-009 ctrl  out  ctrl_t  bundled controls: mem_rd, mem_wr, oe/ld/sel/count for reg file, ir, status, mdr, mar, alu.
REQ-010 state  out  state_e  current state, for debug.
REQ-011 retired  out  CNT_W  count of completed or skipped instructions.
REQ-012 bus_err  out  1  sticky flag: mem_ready timeout.
REQ-013 illegal  out  1  sticky flag: undefined opcode.

Function
REQ-014 SHALL hold state in a register and decode ctrl combinationally from state, ir and mem_ready; every ctrl field not listed for a state SHALL be 0.
REQ-015 FETCH SHALL assert sel_b=PC, oe_b, mem_rd every cycle; ld_ir and count_b=1 only in the cycle mem_ready=1, then go to DECODE; otherwise stay.
REQ-016 DECODE SHALL evaluate cond against status (NONE=always; EQ, NE, LTU, GTU, LEU, GEU, LTS, GTS, LES, GES per standard flag equations; undefined codes=always); ctrl all 0.
REQ-017 DECODE with cond false SHALL go to FETCH and increment retired.
REQ-018 DECODE with cond true SHALL dispatch on op:
- NOP: FETCH, retired+1
- ALU: EXEC
- LD/ST: ADDR
- HALT: STOP, retired+1
- undefined: STOP, illegal=1
REQ-019 EXEC SHALL, for one cycle, assert sel_a=srcA, sel_b=srcB, oe_a, oe_b, alu_op=ir alu_op, oe_alu, ld_reg_file to dst, ld_status; then FETCH, retired+1.
REQ-020 ADDR SHALL, for one cycle, assert sel_a=srcA, oe_a, ld_mar; then MEM.
REQ-021 MEM for LD SHALL assert oe_mar, mem_rd; on mem_ready also ld_reg_file to dst, then FETCH, retired+1.
REQ-022 MEM for ST SHALL assert oe_mar, mem_wr, sel_b=srcB, oe_b; on mem_ready go to FETCH, retired+1.
REQ-023 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0; reaching MAX_WAIT SHALL go to STOP, set bus_err, and drop mem_rd/mem_wr the next cycle.
REQ-024 STOP SHALL drive ctrl all 0 and be left only by rst.
REQ-025 retired SHALL wrap from 2^CNT_W-1 to 0 without flagging.
REQ-026 ir SHALL be sampled only in DECODE, EXEC, ADDR and MEM; ir changes in FETCH SHALL be ignored.

Reset
REQ-027 rst=1 at posedge SHALL set state=FETCH, retired=0, wait counter=0, bus_err=0, illegal=0.
REQ-028 While rst=1, ctrl SHALL be forced to all 0, including mid-MEM; any pending transaction is abandoned.

Structure
REQ-029 status_t, cond_e, reg_e, alu_op_e, plus new op_e, state_e and ctrl_t, SHALL live in package ablomm_cpu.
REQ-030 Condition evaluation SHALL be a separate combinational sub-module cond_eval (inputs: cond_e, status_t; output: 1-bit pass).

Verification
REQ-031 rst, then ir op=NOP, cond=NONE, mem_ready=1 -> FETCH, DECODE, FETCH on cycles 1-3; retired=1.
REQ-032 Hold mem_ready=0 for 3 cycles in FETCH -> mem_rd high 4 cycles; ld_ir and count_b=1 only in the 4th.
REQ-033 cond=EQ with status.zero=0, op=ALU -> no EXEC, no ld_reg_file; retired+1; FETCH next cycle.
REQ-034 ALU with dst=1, srcA=2, srcB=3 -> one EXEC cycle with sel_a=2, sel_b=3, ld_reg_file, ld_status; retired+1.
REQ-035 LD with mem_ready held 0 -> 16 cycles in MEM, then STOP, bus_err=1; ctrl 0 until rst.
REQ-036 rst asserted during ST wait -> mem_wr=0 that cycle; state=FETCH next cycle; bus_err=0, retired=0.

Source files
------------

// File: rtl/control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package    : ablomm_cpu
// Description: Shared types for the control FSM: status flags, condition and
//              opcode encodings, register/ALU selectors, FSM states and the
//              bundled datapath control word.
// Revision   : 1.0 - initial release
// ============================================================================
package ablomm_cpu;

    // Flags produced by a compare a-b. carry is the "no borrow" flag:
    // it is set when a >= b unsigned.
    typedef struct packed {
        logic overflow;
        logic negative;
        logic carry;
        logic zero;
    } status_t;

    // Encodings 11..15 are undefined and evaluate as "always".
    typedef enum logic [3:0] {
        COND_NONE = 4'd0,
        COND_EQ   = 4'd1,
        COND_NE   = 4'd2,
        COND_LTU  = 4'd3,
        COND_GTU  = 4'd4,
        COND_LEU  = 4'd5,
        COND_GEU  = 4'd6,
        COND_LTS  = 4'd7,
        COND_GTS  = 4'd8,
        COND_LES  = 4'd9,
        COND_GES  = 4'd10
    } cond_e;

    typedef enum logic [3:0] {
        R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, SP, LR, PC
    } reg_e;

    typedef enum logic [3:0] {
        ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,  ALU_XOR, ALU_NOT, ALU_SHL,
        ALU_SHR,  ALU_ASR, ALU_ROL, ALU_ROR, ALU_ADC, ALU_SBC, ALU_NEG, ALU_CMP
    } alu_op_e;

    // Encodings 5..15 are undefined and stop the machine with illegal set.
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ALU  = 4'd1,
        OP_LD   = 4'd2,
        OP_ST   = 4'd3,
        OP_HALT = 4'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_ADDR   = 3'd3,
        ST_MEM    = 3'd4,
        ST_STOP   = 3'd5
    } state_e;

    // sel_in names the register-file write port target (dst).
    typedef struct packed {
        logic    mem_rd;
        logic    mem_wr;
        reg_e    sel_a;
        logic    oe_a;
        reg_e    sel_b;
        logic    oe_b;
        reg_e    sel_in;
        logic    ld_reg_file;
        logic    count_b;
        logic    ld_ir;
        logic    ld_status;
        logic    ld_mdr;
        logic    oe_mdr;
        logic    ld_mar;
        logic    oe_mar;
        alu_op_e alu_op;
        logic    oe_alu;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_fsm_if.sv
`default_nettype none
// ============================================================================
// Interface  : control_fsm_if
// Description: Instruction/status/memory-handshake inputs and control/debug
//              outputs of the control FSM. master = FSM side, slave = datapath.
// Revision   : 1.0 - initial release
// ============================================================================
interface control_fsm_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) ();
    import ablomm_cpu::*;

    logic [WIDTH-1:0] ir;
    status_t          status;
    logic             mem_ready;
    ctrl_t            ctrl;
    state_e           state;
    logic [CNT_W-1:0] retired;
    logic             bus_err;
    logic             illegal;

    modport master (
        input  ir, status, mem_ready,
        output ctrl, state, retired, bus_err, illegal
    );

    modport slave (
        output ir, status, mem_ready,
        input  ctrl, state, retired, bus_err, illegal
    );
endinterface
`default_nettype wire

// File: rtl/control_fsm_cond_eval.sv
`default_nettype none
// ============================================================================
// Module     : cond_eval
// Description: Combinational evaluation of an instruction condition code
//              against the status flags of the last compare.
// Revision   : 1.0 - initial release
// ============================================================================
module cond_eval
    import ablomm_cpu::*;
(
    input  wire cond_e   cond_i,
    input  wire status_t status_i,
    output logic         pass_o
);
    logic w_lt_s;

    // Signed less-than holds when negative and overflow disagree.
    assign w_lt_s = status_i.negative ^ status_i.overflow;

    // Flag equations; NONE and undefined codes always pass.
    always_comb begin
        pass_o = 1'b1;
        case (cond_i)
            COND_EQ:  pass_o = status_i.zero;
            COND_NE:  pass_o = !status_i.zero;
            COND_LTU: pass_o = !status_i.carry;
            COND_GTU: pass_o = status_i.carry && !status_i.zero;
            COND_LEU: pass_o = !status_i.carry || status_i.zero;
            COND_GEU: pass_o = status_i.carry;
            COND_LTS: pass_o = w_lt_s;
            COND_GTS: pass_o = !status_i.zero && !w_lt_s;
            COND_LES: pass_o = status_i.zero || w_lt_s;
            COND_GES: pass_o = !w_lt_s;
            default:  pass_o = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module     : control_fsm
// Description: Multi-cycle CPU sequencer. Registered state, retired counter and
//              sticky error flags; control word decoded combinationally from
//              state, ir and mem_ready. WIDTH must be at least 32.
// Revision   : 1.0 - initial release
// ============================================================================
module control_fsm #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  wire           clk,
    input  wire           rst,
    control_fsm_if.master bus
);
    import ablomm_cpu::*;

    localparam int C_WAIT_W = $clog2(MAX_WAIT + 1);

    state_e             state_q;
    logic [C_WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]    retired_q;
    logic                bus_err_q;
    logic                illegal_q;

    cond_e               w_cond;
    op_e                 w_op;
    reg_e                w_dst;
    reg_e                w_src_a;
    reg_e                w_src_b;
    alu_op_e             w_alu_op;
    logic                w_pass;
    logic [C_WAIT_W-1:0] w_wait_inc;
    logic                w_timeout;
    ctrl_t               w_ctrl;

    assign w_cond   = cond_e'(bus.ir[WIDTH-1 -: 4]);
    assign w_op     = op_e'(bus.ir[WIDTH-5 -: 4]);
    assign w_dst    = reg_e'(bus.ir[23:20]);
    assign w_src_a  = reg_e'(bus.ir[19:16]);
    assign w_src_b  = reg_e'(bus.ir[15:12]);
    assign w_alu_op = alu_op_e'(bus.ir[11:8]);

    // One more idle memory cycle would reach the wait limit.
    assign w_wait_inc = wait_q + C_WAIT_W'(1);
    assign w_timeout  = (w_wait_inc == C_WAIT_W'(MAX_WAIT));

    cond_eval u_cond_eval (
        .cond_i   (w_cond),
        .status_i (bus.status),
        .pass_o   (w_pass)
    );

    // Sequencer: state, memory wait counter, retired count and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        state_q <= ST_DECODE;
                    end else if (w_timeout) begin
                        state_q   <= ST_STOP;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_q <= w_wait_inc;
                    end
                end
                ST_DECODE: begin
                    if (!w_pass) begin
                        state_q   <= ST_FETCH;
                        wait_q    <= '0;
                        retired_q <= retired_q + CNT_W'(1);
                    end else begin
                        case (w_op)
                            OP_NOP: begin
                                state_q   <= ST_FETCH;
                                wait_q    <= '0;
                                retired_q <= retired_q + CNT_W'(1);
                            end
                            OP_ALU:  state_q <= ST_EXEC;
                            OP_LD,
                            OP_ST:   state_q <= ST_ADDR;
                            OP_HALT: begin
                                state_q   <= ST_STOP;
                                retired_q <= retired_q + CNT_W'(1);
                            end
                            default: begin
                                state_q   <= ST_STOP;
                                illegal_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    state_q   <= ST_FETCH;
                    wait_q    <= '0;
                    retired_q <= retired_q + CNT_W'(1);
                end
                ST_ADDR: begin
                    state_q <= ST_MEM;
                    wait_q  <= '0;
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        state_q   <= ST_FETCH;
                        wait_q    <= '0;
                        retired_q <= retired_q + CNT_W'(1);
                    end else if (w_timeout) begin
                        state_q   <= ST_STOP;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_q <= w_wait_inc;
                    end
                end
                ST_STOP: state_q <= ST_STOP;
                default: state_q <= ST_STOP;
            endcase
        end
    end

    // Control word decode; reset masks everything so an open bus cycle is dropped.
    always_comb begin
        w_ctrl = '0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    w_ctrl.sel_b   = PC;
                    w_ctrl.oe_b    = 1'b1;
                    w_ctrl.mem_rd  = 1'b1;
                    w_ctrl.ld_ir   = bus.mem_ready;
                    w_ctrl.count_b = bus.mem_ready;
                end
                ST_EXEC: begin
                    w_ctrl.sel_a       = w_src_a;
                    w_ctrl.sel_b       = w_src_b;
                    w_ctrl.oe_a        = 1'b1;
                    w_ctrl.oe_b        = 1'b1;
                    w_ctrl.alu_op      = w_alu_op;
                    w_ctrl.oe_alu      = 1'b1;
                    w_ctrl.sel_in      = w_dst;
                    w_ctrl.ld_reg_file = 1'b1;
                    w_ctrl.ld_status   = 1'b1;
                end
                ST_ADDR: begin
                    w_ctrl.sel_a  = w_src_a;
                    w_ctrl.oe_a   = 1'b1;
                    w_ctrl.ld_mar = 1'b1;
                end
                ST_MEM: begin
                    w_ctrl.oe_mar = 1'b1;
                    if (w_op == OP_ST) begin
                        w_ctrl.mem_wr = 1'b1;
                        w_ctrl.sel_b  = w_src_b;
                        w_ctrl.oe_b   = 1'b1;
                    end else begin
                        w_ctrl.mem_rd = 1'b1;
                        if (bus.mem_ready) begin
                            w_ctrl.sel_in      = w_dst;
                            w_ctrl.ld_reg_file = 1'b1;
                        end
                    end
                end
                default: w_ctrl = '0;
            endcase
        end
    end

    assign bus.ctrl    = w_ctrl;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;
    assign bus.bus_err = bus_err_q;
    assign bus.illegal = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module     : tb_control_fsm
// Description: Self-checking bench for control_fsm. Condition outcomes come
//              from real operand comparisons; control words from the state
//              tables of the instruction set.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_control_fsm;
    import ablomm_cpu::*;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_fsm_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    control_fsm #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] exp_ret  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input state_e s, input ctrl_t c);
        #1;
        chk({tag, "/state"}, 64'(bus.state), 64'(s));
        chk({tag, "/ctrl"}, 64'(bus.ctrl), 64'(c));
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op,
                                       input logic [3:0] dst, input logic [3:0] sa,
                                       input logic [3:0] sb, input logic [3:0] alu);
        logic [7:0] low;
        low = 8'($urandom);
        return {cond, op, dst, sa, sb, alu, low};
    endfunction

    function automatic status_t flags_of(input logic [31:0] a, input logic [31:0] b);
        status_t    s;
        logic [31:0] d;
        d          = a - b;
        s.zero     = (d == 32'd0);
        s.carry    = (a >= b);
        s.negative = d[31];
        s.overflow = (a[31] != b[31]) && (d[31] != a[31]);
        return s;
    endfunction

    function automatic bit ref_pass(input logic [3:0] cond, input logic [31:0] a, input logic [31:0] b);
        case (cond)
            4'd1:    return a == b;
            4'd2:    return a != b;
            4'd3:    return a < b;
            4'd4:    return a > b;
            4'd5:    return a <= b;
            4'd6:    return a >= b;
            4'd7:    return $signed(a) <  $signed(b);
            4'd8:    return $signed(a) >  $signed(b);
            4'd9:    return $signed(a) <= $signed(b);
            4'd10:   return $signed(a) >= $signed(b);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7fff_ffff;
            3:       return 32'h8000_0000;
            4:       return 32'hffff_ffff;
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic ctrl_t exp_fetch(input bit ready);
        ctrl_t c = '0;
        c.sel_b = PC; c.oe_b = 1'b1; c.mem_rd = 1'b1;
        c.ld_ir = ready; c.count_b = ready;
        return c;
    endfunction

    function automatic ctrl_t exp_exec(input logic [31:0] ir);
        ctrl_t c = '0;
        c.sel_a = reg_e'(ir[19:16]); c.oe_a = 1'b1;
        c.sel_b = reg_e'(ir[15:12]); c.oe_b = 1'b1;
        c.alu_op = alu_op_e'(ir[11:8]); c.oe_alu = 1'b1;
        c.sel_in = reg_e'(ir[23:20]); c.ld_reg_file = 1'b1; c.ld_status = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t exp_addr(input logic [31:0] ir);
        ctrl_t c = '0;
        c.sel_a = reg_e'(ir[19:16]); c.oe_a = 1'b1; c.ld_mar = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t exp_mem(input logic [31:0] ir, input bit ready);
        ctrl_t c = '0;
        c.oe_mar = 1'b1;
        if (ir[27:24] == 4'd3) begin
            c.mem_wr = 1'b1; c.sel_b = reg_e'(ir[15:12]); c.oe_b = 1'b1;
        end else begin
            c.mem_rd = 1'b1;
            if (ready) begin
                c.sel_in = reg_e'(ir[23:20]); c.ld_reg_file = 1'b1;
            end
        end
        return c;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_fetch(input string tag, input int fw);
        for (int i = 0; i < fw; i++) begin
            bus.ir = $urandom; bus.mem_ready = 1'b0;
            expect_cycle({tag, "/fetch_wait"}, ST_FETCH, exp_fetch(1'b0));
            tick();
        end
        bus.ir = $urandom; bus.mem_ready = 1'b1;
        expect_cycle({tag, "/fetch_rdy"}, ST_FETCH, exp_fetch(1'b1));
        tick();
    endtask

    task automatic do_decode(input string tag, input logic [31:0] ir, input status_t st);
        bus.ir = ir; bus.status = st; bus.mem_ready = 1'($urandom);
        expect_cycle({tag, "/decode"}, ST_DECODE, '0);
        tick();
    endtask

    task automatic check_flags(input string tag, input state_e s, input bit berr, input bit ill);
        #1;
        chk({tag, "/next_state"}, 64'(bus.state), 64'(s));
        chk({tag, "/retired"}, 64'(bus.retired), 64'(exp_ret));
        chk({tag, "/bus_err"}, 64'(bus.bus_err), 64'(berr));
        chk({tag, "/illegal"}, 64'(bus.illegal), 64'(ill));
    endtask

    // Full NOP/ALU/LD/ST instruction with operands feeding the condition flags.
    task automatic run_instr(input string tag, input logic [31:0] ir, input logic [31:0] a,
                             input logic [31:0] b, input int fw, input int mw);
        logic [3:0] op;
        op = ir[27:24];
        do_fetch(tag, fw);
        do_decode(tag, ir, flags_of(a, b));
        if (ref_pass(ir[31:28], a, b) && op != 4'd0) begin
            if (op == 4'd1) begin
                bus.mem_ready = 1'($urandom);
                expect_cycle({tag, "/exec"}, ST_EXEC, exp_exec(ir));
                tick();
            end else begin
                bus.mem_ready = 1'($urandom);
                expect_cycle({tag, "/addr"}, ST_ADDR, exp_addr(ir));
                tick();
                for (int i = 0; i < mw; i++) begin
                    bus.mem_ready = 1'b0;
                    expect_cycle({tag, "/mem_wait"}, ST_MEM, exp_mem(ir, 1'b0));
                    tick();
                end
                bus.mem_ready = 1'b1;
                expect_cycle({tag, "/mem_rdy"}, ST_MEM, exp_mem(ir, 1'b1));
                tick();
            end
        end
        exp_ret = CNT_W'(exp_ret + 1);
        check_flags(tag, ST_FETCH, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; bus.mem_ready = 1'b1;
        #1;
        chk({tag, "/ctrl_in_rst"}, 64'(bus.ctrl), 64'd0);
        tick();
        rst = 1'b0;
        exp_ret = '0;
        check_flags({tag, "/after_rst"}, ST_FETCH, 1'b0, 1'b0);
    endtask

    task automatic hold_stop(input string tag);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'($urandom); bus.ir = $urandom;
            expect_cycle({tag, "/stop"}, ST_STOP, '0);
            tick();
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] ir;
        logic [3:0]  op;

        rst = 1'b1; bus.ir = '0; bus.status = '0; bus.mem_ready = 1'b1;
        tick(); tick();
        chk("reset/ctrl", 64'(bus.ctrl), 64'd0);
        chk("reset/state", 64'(bus.state), 64'(ST_FETCH));
        rst = 1'b0;
        check_flags("reset", ST_FETCH, 1'b0, 1'b0);

        run_instr("nop_none", mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), 32'd0, 32'd0, 0, 0);
        run_instr("fetch_wait3", mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), 32'd0, 32'd0, 3, 0);
        run_instr("eq_false_alu", mk(4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd1), 32'd1, 32'd2, 0, 0);
        run_instr("alu_1_2_3", mk(4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd2), 32'd5, 32'd5, 1, 0);
        run_instr("ld_basic", mk(4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd0), 32'd0, 32'd0, 0, 2);
        run_instr("st_basic", mk(4'd0, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0), 32'd0, 32'd0, 0, 1);

        // Random mix; the 4-bit retired counter wraps several times.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       op = 4'd0;
                1:       op = 4'd1;
                2:       op = 4'd2;
                default: op = 4'd3;
            endcase
            ir = mk(4'($urandom_range(0, 15)), op, 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom));
            run_instr("random", ir, pick(), pick(), $urandom_range(0, 3), $urandom_range(0, 5));
        end

        ir = mk(4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0);
        do_fetch("halt", 0);
        do_decode("halt", ir, '0);
        exp_ret = CNT_W'(exp_ret + 1);
        check_flags("halt", ST_STOP, 1'b0, 1'b0);
        hold_stop("halt");
        do_reset("halt");

        run_instr("pre_illegal", mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), 32'd0, 32'd0, 0, 0);
        ir = mk(4'd0, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0);
        do_fetch("illegal", 0);
        do_decode("illegal", ir, '0);
        check_flags("illegal", ST_STOP, 1'b0, 1'b1);
        hold_stop("illegal");
        do_reset("illegal");

        ir = mk(4'd0, 4'd2, 4'd7, 4'd8, 4'd9, 4'd0);
        do_fetch("ld_timeout", 0);
        do_decode("ld_timeout", ir, '0);
        bus.mem_ready = 1'b0;
        expect_cycle("ld_timeout/addr", ST_ADDR, exp_addr(ir));
        tick();
        for (int i = 0; i < MAX_WAIT; i++) begin
            bus.mem_ready = 1'b0;
            expect_cycle("ld_timeout/mem", ST_MEM, exp_mem(ir, 1'b0));
            tick();
        end
        check_flags("ld_timeout", ST_STOP, 1'b1, 1'b0);
        hold_stop("ld_timeout");
        do_reset("ld_timeout");

        for (int i = 0; i < MAX_WAIT; i++) begin
            bus.mem_ready = 1'b0;
            expect_cycle("fetch_timeout/fetch", ST_FETCH, exp_fetch(1'b0));
            tick();
        end
        check_flags("fetch_timeout", ST_STOP, 1'b1, 1'b0);
        do_reset("fetch_timeout");

        run_instr("pre_st_rst", mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), 32'd0, 32'd0, 0, 0);
        ir = mk(4'd0, 4'd3, 4'd1, 4'd2, 4'd3, 4'd0);
        do_fetch("st_rst", 1);
        do_decode("st_rst", ir, '0);
        bus.mem_ready = 1'b0;
        expect_cycle("st_rst/addr", ST_ADDR, exp_addr(ir));
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.mem_ready = 1'b0;
            expect_cycle("st_rst/mem_wait", ST_MEM, exp_mem(ir, 1'b0));
            tick();
        end
        rst = 1'b1; bus.mem_ready = 1'b0;
        #1;
        chk("st_rst/mem_wr_in_rst", 64'(bus.ctrl.mem_wr), 64'd0);
        chk("st_rst/ctrl_in_rst", 64'(bus.ctrl), 64'd0);
        tick();
        rst = 1'b0;
        exp_ret = '0;
        check_flags("st_rst", ST_FETCH, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of sequence, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
